// File: rtl/bottling_pkg.sv
// ============================================================================
//  bottling_pkg
//  Shared constants, state encoding and BCD helpers for the bottling controller.
//  Rev 1.0  initial release
// ============================================================================
`default_nettype none

package bottling_pkg;

  localparam int NUM_DIGITS = 5;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [2:0] POS_P1 = 3'd0;
  localparam logic [2:0] POS_P2 = 3'd1;
  localparam logic [2:0] POS_P3 = 3'd2;
  localparam logic [2:0] POS_B1 = 3'd3;
  localparam logic [2:0] POS_B2 = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_REJECT = 2'd2;
  localparam logic [1:0] ST_ARMED  = 2'd3;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [2:0] pos_inc(input logic [2:0] p);
    return (p >= POS_B2) ? POS_P1 : p + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/target_setter_if.sv
// ============================================================================
//  target_setter_if
//  Front-panel keys in, target digits / cursor / status out.
//  Rev 1.0  initial release
// ============================================================================
`default_nettype none

interface target_setter_if;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_start;
  logic       edit_en;
  logic [3:0] target_pills1;
  logic [3:0] target_pills2;
  logic [3:0] target_pills3;
  logic [3:0] target_bottles1;
  logic [3:0] target_bottles2;
  logic [2:0] position;
  logic [4:0] flicker_mask;
  logic       start_pulse;
  logic       cfg_error;

  modport slave (
    input  btn_inc, btn_next, btn_start, edit_en,
    output target_pills1, target_pills2, target_pills3,
           target_bottles1, target_bottles2,
           position, flicker_mask, start_pulse, cfg_error
  );

  modport master (
    output btn_inc, btn_next, btn_start, edit_en,
    input  target_pills1, target_pills2, target_pills3,
           target_bottles1, target_bottles2,
           position, flicker_mask, start_pulse, cfg_error
  );
endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  btn_debounce
//  Stability-counter debouncer; emits a one-cycle pulse on each debounced press.
//  Rev 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  raw,
  output logic level,
  output logic press
);

  localparam int             c_cw    = $clog2(DEBOUNCE_MS + 1);
  localparam logic [c_cw-1:0] c_limit = c_cw'(DEBOUNCE_MS - 1);

  logic [c_cw-1:0] r_cnt;
  logic            r_level;
  logic            r_press;

  // Any sample agreeing with the current level restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (raw == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_limit) begin
        r_cnt   <= '0;
        r_level <= raw;
        r_press <= raw;
      end else begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/target_setter.sv
// ============================================================================
//  target_setter
//  SETTING-phase key sequencer: edits five BCD target digits and issues start.
//  Optional auto-repeat on the increment key: TARGET_SETTER_AUTOREPEAT_EN.
//  Rev 1.0  initial release
// ============================================================================
`default_nettype none

module target_setter
  import bottling_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 125
) (
  input wire            clk_1khz,
  input wire            switch_clr,
  target_setter_if.slave bus
);

  logic w_inc_level, w_inc_press;
  logic w_next_level, w_next_press;
  logic w_start_level, w_start_press;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_inc (
    .clk(clk_1khz), .rst(switch_clr), .raw(bus.btn_inc),
    .level(w_inc_level), .press(w_inc_press));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_next (
    .clk(clk_1khz), .rst(switch_clr), .raw(bus.btn_next),
    .level(w_next_level), .press(w_next_press));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
    .clk(clk_1khz), .rst(switch_clr), .raw(bus.btn_start),
    .level(w_start_level), .press(w_start_press));

  logic [1:0] r_state, w_state_next;
  logic [3:0] r_digit [NUM_DIGITS];
  logic [3:0] w_digit_next [NUM_DIGITS];
  logic [2:0] r_pos, w_pos_next;
  logic [4:0] r_mask, w_mask_next;
  logic       r_err, w_err_next;
  logic       r_sp, w_sp_next;
  logic       w_inc_evt;

`ifdef TARGET_SETTER_AUTOREPEAT_EN
  localparam int              c_rw     = $clog2(((HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS) + 1);
  localparam logic [c_rw-1:0] c_hold   = c_rw'(HOLD_MS);
  localparam logic [c_rw-1:0] c_repeat = c_rw'(REPEAT_MS);

  logic [c_rw-1:0] r_rep_cnt;
  logic            r_rep_first;
  logic            w_rep_fire;
  logic            w_unused_levels;

  assign w_rep_fire = w_inc_level && !w_inc_press &&
                      (r_rep_cnt == (r_rep_first ? c_hold : c_repeat));

  // Counts cycles since the press or the previous repeat while the key stays down.
  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_inc_press) begin
      r_rep_cnt   <= c_rw'(1);
      r_rep_first <= 1'b1;
    end else if (!w_inc_level) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= c_rw'(1);
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + c_rw'(1);
    end
  end

  assign w_inc_evt       = w_inc_press || (w_rep_fire && (r_state == ST_EDIT));
  assign w_unused_levels = w_next_level ^ w_start_level;
`else
  localparam int c_unused_timing = HOLD_MS + REPEAT_MS;
  logic          w_unused_levels;

  assign w_inc_evt       = w_inc_press;
  assign w_unused_levels = w_inc_level ^ w_next_level ^ w_start_level;
`endif

  // Priority start > next > inc: lower-priority events are masked out.
  logic w_ev_start, w_ev_next, w_ev_inc, w_valid, w_active;
  assign w_ev_start = w_start_press;
  assign w_ev_next  = w_next_press && !w_start_press;
  assign w_ev_inc   = w_inc_evt && !w_next_press && !w_start_press;
  assign w_valid    = ({r_digit[POS_P3], r_digit[POS_P2], r_digit[POS_P1]} != 12'd0) &&
                      ({r_digit[POS_B2], r_digit[POS_B1]} != 8'd0);
  assign w_active   = bus.edit_en && ((r_state == ST_EDIT) || (r_state == ST_REJECT));

  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.edit_en) w_state_next = ST_EDIT;
      ST_EDIT, ST_REJECT: begin
        if (!bus.edit_en)              w_state_next = ST_IDLE;
        else if (w_ev_start)           w_state_next = w_valid ? ST_ARMED : ST_REJECT;
        else if (w_ev_next || w_ev_inc) w_state_next = ST_EDIT;
      end
      ST_ARMED:  if (!bus.edit_en) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) w_digit_next[i] = r_digit[i];
    w_pos_next = r_pos;
    w_err_next = r_err;
    w_sp_next  = 1'b0;
    if (w_active) begin
      if (w_ev_start) begin
        w_sp_next  = w_valid;
        w_err_next = !w_valid;
      end else if (w_ev_next) begin
        w_pos_next = pos_inc(r_pos);
        w_err_next = 1'b0;
      end else if (w_ev_inc) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (r_pos == 3'(i)) w_digit_next[i] = bcd_inc(r_digit[i]);
        w_err_next = 1'b0;
      end
    end else if (w_state_next == ST_IDLE) begin
      w_err_next = 1'b0;
    end
    case (w_state_next)
      ST_EDIT:   w_mask_next = 5'(1) << w_pos_next;
      ST_REJECT: w_mask_next = 5'b11111;
      default:   w_mask_next = 5'b00000;
    endcase
  end

  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'd0;
      r_pos  <= POS_P1;
      r_mask <= 5'b00000;
      r_err  <= 1'b0;
      r_sp   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_digit_next[i];
      r_pos  <= w_pos_next;
      r_mask <= w_mask_next;
      r_err  <= w_err_next;
      r_sp   <= w_sp_next;
    end
  end

  assign bus.target_pills1   = r_digit[POS_P1];
  assign bus.target_pills2   = r_digit[POS_P2];
  assign bus.target_pills3   = r_digit[POS_P3];
  assign bus.target_bottles1 = r_digit[POS_B1];
  assign bus.target_bottles2 = r_digit[POS_B2];
  assign bus.position        = r_pos;
  assign bus.flicker_mask    = r_mask;
  assign bus.start_pulse     = r_sp;
  assign bus.cfg_error       = r_err;

endmodule

`default_nettype wire
